// File: rtl/pemstat_cntbank.sv
// Bank of NCH statistics counters with per-channel multi-unit increments, wrap or
// saturate overflow, clear-on-read, host load, sticky carry flags and a carry interrupt.
module pemstat_cntbank #(
    parameter int NCH  = 8,
    parameter int CW   = 12,
    parameter int INCW = 1,
    parameter int SAT  = 0,
    parameter int AW   = 5,
    parameter int DLY  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       inc_vld,
    input  logic [NCH*INCW-1:0]  inc_amt,
    input  logic                 cor_en,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [AW-1:0]        addr,
    input  logic [30:0]          wdata,
    output logic [30:0]          rdata,
    output logic                 rd_vld,
    input  logic [NCH-1:0]       carry_clr,
    input  logic [NCH-1:0]       carry_mask,
    output logic [NCH-1:0]       carry,
    output logic                 carry_irq
);

    // DLY only shaped update timing in older simulation models; it has no effect on this logic.
    localparam int unused_dly = DLY;

    logic [NCH*CW-1:0] cnt_flat;
    logic [CW-1:0]     rd_sel;

    if (CW < 31) begin : g_wdata_unused
        logic unused_wdata;
        assign unused_wdata = ^wdata[30:CW];
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [INCW-1:0] amt;
        logic [CW:0]     sum;
        logic [CW-1:0]   cnt;
        logic [CW-1:0]   cnt_nxt;
        logic            rd_hit;
        logic            wr_hit;
        logic            carry_set;
        logic            carry_q;

        assign amt    = inc_amt[n*INCW +: INCW];
        assign rd_hit = rd_en && (addr == AW'(n));
        assign wr_hit = wr_en && (addr == AW'(n));
        assign sum    = {1'b0, cnt} + (CW+1)'(amt);

        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        always_comb begin
            cnt_nxt   = cnt;
            carry_set = 1'b0;
            if (wr_hit) begin
                cnt_nxt = wdata[CW-1:0];
            end else if (rd_hit && cor_en) begin
                // An increment landing on the clearing read starts the next interval.
                cnt_nxt = inc_vld[n] ? CW'(amt) : '0;
            end else if (inc_vld[n]) begin
                carry_set = sum[CW];
                cnt_nxt   = (sum[CW] && SAT != 0) ? '1 : sum[CW-1:0];
            end
        end

        // NOTE: the counters are a handful of flops rather than a RAM, so each one is reset to zero
        // and state is updated with non-blocking assignments only.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt     <= '0;
                carry_q <= 1'b0;
            end else begin
                cnt <= cnt_nxt;
                if (carry_clr[n]) begin
                    carry_q <= 1'b0;
                end else if (carry_set) begin
                    carry_q <= 1'b1;
                end
            end
        end

        assign cnt_flat[n*CW +: CW] = cnt;
        assign carry[n]             = carry_q;
    end

    // Out-of-range addresses match no channel and read back as zero.
    always_comb begin
        rd_sel = '0;
        for (int n = 0; n < NCH; n++) begin
            if (addr == AW'(n)) begin
                rd_sel = cnt_flat[n*CW +: CW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata     <= '0;
            rd_vld    <= 1'b0;
            carry_irq <= 1'b0;
        end else begin
            rd_vld    <= rd_en;
            carry_irq <= |(carry & ~carry_mask);
            if (rd_en) begin
                rdata <= 31'(rd_sel);
            end
        end
    end

endmodule

// File: tb/tb_pemstat_cntbank.sv
// Self-checking bench for pemstat_cntbank: directed vector table, saturate-mode sequence,
// randomized traffic against an arithmetic reference model, and an asynchronous reset pulse.
module tb_pemstat_cntbank;

    localparam int NCH  = 4;
    localparam int CW   = 12;
    localparam int INCW = 4;
    localparam int AW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      inc_vld;
    logic [NCH*INCW-1:0] inc_amt;
    logic                cor_en, rd_en, wr_en;
    logic [AW-1:0]       addr;
    logic [30:0]         wdata;
    logic [NCH-1:0]      carry_clr, carry_mask;

    logic [30:0]    rdata_w, rdata_s;
    logic           rd_vld_w, rd_vld_s;
    logic [NCH-1:0] carry_w, carry_s;
    logic           irq_w, irq_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pemstat_cntbank #(.NCH(NCH), .CW(CW), .INCW(INCW), .SAT(0), .AW(AW), .DLY(1)) u_wrap (
        .clk(clk), .rst(rst), .inc_vld(inc_vld), .inc_amt(inc_amt), .cor_en(cor_en),
        .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata_w),
        .rd_vld(rd_vld_w), .carry_clr(carry_clr), .carry_mask(carry_mask),
        .carry(carry_w), .carry_irq(irq_w)
    );

    pemstat_cntbank #(.NCH(NCH), .CW(CW), .INCW(INCW), .SAT(1), .AW(AW), .DLY(1)) u_sat (
        .clk(clk), .rst(rst), .inc_vld(inc_vld), .inc_amt(inc_amt), .cor_en(cor_en),
        .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata_s),
        .rd_vld(rd_vld_s), .carry_clr(carry_clr), .carry_mask(carry_mask),
        .carry(carry_s), .carry_irq(irq_s)
    );

    // Reference model, index 0 = wrap instance, 1 = saturate instance.
    int             m_cnt   [2][NCH];
    logic [NCH-1:0] m_carry [2];
    logic [30:0]    m_rdata [2];
    logic           m_irq   [2];
    logic           m_vld;

    typedef struct {
        logic [NCH-1:0]      iv;
        logic [NCH*INCW-1:0] ia;
        logic                cor;
        logic                rd;
        logic                wr;
        logic [AW-1:0]       ad;
        logic [30:0]         wd;
        logic [NCH-1:0]      clr;
        logic [NCH-1:0]      msk;
        logic [30:0]         e_rdata;
        logic                e_vld;
        logic [NCH-1:0]      e_carry;
        logic                e_irq;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NCH-1:0] iv, input logic [15:0] ia, input logic cor,
                                input logic rd, input logic wr, input logic [AW-1:0] ad,
                                input logic [30:0] wd, input logic [NCH-1:0] clr,
                                input logic [NCH-1:0] msk, input logic [30:0] er, input logic ev,
                                input logic [NCH-1:0] ec, input logic ei);
        vec_t v;
        v.iv = iv; v.ia = ia; v.cor = cor; v.rd = rd; v.wr = wr; v.ad = ad; v.wd = wd;
        v.clr = clr; v.msk = msk; v.e_rdata = er; v.e_vld = ev; v.e_carry = ec; v.e_irq = ei;
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) m_cnt[d][c] = 0;
            m_carry[d] = '0;
            m_rdata[d] = '0;
            m_irq[d]   = 1'b0;
        end
        m_vld = 1'b0;
    endtask

    // Applies the behavioural rules to the pre-edge state and the current inputs.
    task automatic model_edge();
        int a;
        a = int'(addr);
        for (int d = 0; d < 2; d++) begin
            logic irq_n;
            irq_n = |(m_carry[d] & ~carry_mask);
            if (rd_en) m_rdata[d] = (a < NCH) ? 31'(m_cnt[d][a]) : 31'(0);
            for (int c = 0; c < NCH; c++) begin
                int  amt, s;
                bit  rdh, wrh, ovf;
                amt = int'((inc_amt >> (INCW * c)) & 16'hF);
                rdh = rd_en && (a == c);
                wrh = wr_en && (a == c);
                ovf = 0;
                if (wrh) m_cnt[d][c] = int'(wdata) & CMAX;
                else if (rdh && cor_en) m_cnt[d][c] = inc_vld[c] ? amt : 0;
                else if (inc_vld[c]) begin
                    s = m_cnt[d][c] + amt;
                    if (s > CMAX) begin
                        ovf = 1;
                        s = (d == 1) ? CMAX : s - (CMAX + 1);
                    end
                    m_cnt[d][c] = s;
                end
                if (carry_clr[c]) m_carry[d][c] = 1'b0;
                else if (ovf) m_carry[d][c] = 1'b1;
            end
            m_irq[d] = irq_n;
        end
        m_vld = rd_en;
    endtask

    task automatic compare_all(input string tag);
        check({tag, " wrap.rdata"}, 32'(rdata_w), 32'(m_rdata[0]));
        check({tag, " wrap.rd_vld"}, 32'(rd_vld_w), 32'(m_vld));
        check({tag, " wrap.carry"}, 32'(carry_w), 32'(m_carry[0]));
        check({tag, " wrap.irq"}, 32'(irq_w), 32'(m_irq[0]));
        check({tag, " sat.rdata"}, 32'(rdata_s), 32'(m_rdata[1]));
        check({tag, " sat.rd_vld"}, 32'(rd_vld_s), 32'(m_vld));
        check({tag, " sat.carry"}, 32'(carry_s), 32'(m_carry[1]));
        check({tag, " sat.irq"}, 32'(irq_s), 32'(m_irq[1]));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle();
        inc_vld = '0; inc_amt = '0; cor_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        addr = '0; wdata = '0; carry_clr = '0; carry_mask = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " wrap.rdata"}, 32'(rdata_w), 32'd0);
        check({tag, " wrap.rd_vld"}, 32'(rd_vld_w), 32'd0);
        check({tag, " wrap.carry"}, 32'(carry_w), 32'd0);
        check({tag, " wrap.irq"}, 32'(irq_w), 32'd0);
        check({tag, " sat.rdata"}, 32'(rdata_s), 32'd0);
        check({tag, " sat.rd_vld"}, 32'(rd_vld_s), 32'd0);
        check({tag, " sat.carry"}, 32'(carry_s), 32'd0);
        check({tag, " sat.irq"}, 32'(irq_s), 32'd0);
    endtask

    initial begin
        //           iv       ia        cor rd wr ad wdata    clr      msk      e_rdata e_vld e_carry  e_irq
        vecs[0]  = mk(4'b0000, 16'h0000, 0, 0, 1, 1, 31'hFFE, 4'b0000, 4'b0000, 31'h000, 0, 4'b0000, 0);
        vecs[1]  = mk(4'b0010, 16'h0030, 0, 0, 0, 0, 31'h000, 4'b0000, 4'b0000, 31'h000, 0, 4'b0010, 0);
        vecs[2]  = mk(4'b0000, 16'h0000, 0, 0, 0, 0, 31'h000, 4'b0000, 4'b0000, 31'h000, 0, 4'b0010, 1);
        vecs[3]  = mk(4'b0000, 16'h0000, 0, 1, 0, 1, 31'h000, 4'b0000, 4'b0000, 31'h001, 1, 4'b0010, 1);
        vecs[4]  = mk(4'b0000, 16'h0000, 0, 0, 1, 1, 31'hFFF, 4'b0000, 4'b0000, 31'h001, 0, 4'b0010, 1);
        vecs[5]  = mk(4'b0010, 16'h0020, 0, 0, 0, 0, 31'h000, 4'b0010, 4'b0000, 31'h001, 0, 4'b0000, 1);
        vecs[6]  = mk(4'b0000, 16'h0000, 0, 0, 0, 0, 31'h000, 4'b0000, 4'b0000, 31'h001, 0, 4'b0000, 0);
        vecs[7]  = mk(4'b0000, 16'h0000, 0, 0, 1, 0, 31'h123, 4'b0000, 4'b0000, 31'h001, 0, 4'b0000, 0);
        vecs[8]  = mk(4'b0001, 16'h0002, 1, 1, 0, 0, 31'h000, 4'b0000, 4'b0000, 31'h123, 1, 4'b0000, 0);
        vecs[9]  = mk(4'b0000, 16'h0000, 0, 1, 0, 0, 31'h000, 4'b0000, 4'b0000, 31'h002, 1, 4'b0000, 0);
        vecs[10] = mk(4'b0000, 16'h0000, 0, 0, 1, 0, 31'h123, 4'b0000, 4'b0000, 31'h002, 0, 4'b0000, 0);
        vecs[11] = mk(4'b0001, 16'h0002, 0, 1, 0, 0, 31'h000, 4'b0000, 4'b0000, 31'h123, 1, 4'b0000, 0);
        vecs[12] = mk(4'b0000, 16'h0000, 0, 1, 0, 0, 31'h000, 4'b0000, 4'b0000, 31'h125, 1, 4'b0000, 0);
        vecs[13] = mk(4'b0000, 16'h0000, 0, 0, 1, 3, 31'h050, 4'b0000, 4'b0000, 31'h125, 0, 4'b0000, 0);
        vecs[14] = mk(4'b0000, 16'h0000, 1, 1, 1, 3, 31'h0AA, 4'b0000, 4'b0000, 31'h050, 1, 4'b0000, 0);
        vecs[15] = mk(4'b0000, 16'h0000, 0, 1, 0, 3, 31'h000, 4'b0000, 4'b0000, 31'h0AA, 1, 4'b0000, 0);
        vecs[16] = mk(4'b0000, 16'h0000, 1, 1, 0, 7, 31'h000, 4'b0000, 4'b0000, 31'h000, 1, 4'b0000, 0);
        vecs[17] = mk(4'b0000, 16'h0000, 0, 1, 0, 0, 31'h000, 4'b0000, 4'b0000, 31'h125, 1, 4'b0000, 0);
        vecs[18] = mk(4'b0000, 16'h0000, 0, 1, 0, 3, 31'h000, 4'b0000, 4'b0000, 31'h0AA, 1, 4'b0000, 0);
        vecs[19] = mk(4'b0000, 16'h0000, 0, 0, 1, 1, 31'hFFF, 4'b0000, 4'b0010, 31'h0AA, 0, 4'b0000, 0);
        vecs[20] = mk(4'b0010, 16'h0010, 0, 0, 0, 0, 31'h000, 4'b0000, 4'b0010, 31'h0AA, 0, 4'b0010, 0);
        vecs[21] = mk(4'b0000, 16'h0000, 0, 0, 0, 0, 31'h000, 4'b0000, 4'b0010, 31'h0AA, 0, 4'b0010, 0);
        vecs[22] = mk(4'b0000, 16'h0000, 0, 0, 0, 0, 31'h000, 4'b0000, 4'b0000, 31'h0AA, 0, 4'b0010, 1);
        vecs[23] = mk(4'b0000, 16'h0000, 0, 1, 0, 1, 31'h000, 4'b0000, 4'b0000, 31'h000, 1, 4'b0010, 1);

        rst = 1'b1;
        idle();
        model_reset();
        #1;
        check_all_zero("reset_initial");
        #11;
        rst = 1'b0;

        // Directed table, checked against both the hand-derived table and the model.
        for (int i = 0; i < 24; i++) begin
            inc_vld = vecs[i].iv; inc_amt = vecs[i].ia; cor_en = vecs[i].cor;
            rd_en = vecs[i].rd; wr_en = vecs[i].wr; addr = vecs[i].ad; wdata = vecs[i].wd;
            carry_clr = vecs[i].clr; carry_mask = vecs[i].msk;
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl.rdata", i), 32'(rdata_w), 32'(vecs[i].e_rdata));
            check($sformatf("vec%0d tbl.rd_vld", i), 32'(rd_vld_w), 32'(vecs[i].e_vld));
            check($sformatf("vec%0d tbl.carry", i), 32'(carry_w), 32'(vecs[i].e_carry));
            check($sformatf("vec%0d tbl.irq", i), 32'(irq_w), 32'(vecs[i].e_irq));
        end

        // Saturate-mode overflow on ch2, run on both instances side by side.
        idle(); wr_en = 1'b1; addr = 5'd2; wdata = 31'hFFD;
        step("sat_load");
        idle(); inc_vld = 4'b0100; inc_amt = 16'h0500;
        step("sat_inc5");
        check("sat_inc5 sat.carry2", 32'(carry_s[2]), 32'd1);
        check("sat_inc5 wrap.carry2", 32'(carry_w[2]), 32'd1);
        idle(); inc_vld = 4'b0100; inc_amt = 16'h0100;
        step("sat_inc1");
        idle(); rd_en = 1'b1; addr = 5'd2;
        step("sat_read");
        check("sat_read sat.count", 32'(rdata_s), 32'h0000_0FFF);
        check("sat_read wrap.count", 32'(rdata_w), 32'h0000_0003);

        // Randomized traffic, with loads biased near the top to provoke overflows.
        for (int i = 0; i < 400; i++) begin
            inc_vld    = 4'($urandom);
            inc_amt    = 16'($urandom);
            cor_en     = 1'($urandom_range(0, 1));
            rd_en      = ($urandom_range(0, 2) == 0);
            wr_en      = ($urandom_range(0, 7) == 0);
            addr       = 5'($urandom_range(0, 7));
            wdata      = ($urandom_range(0, 1) == 1) ? 31'(12'hFF0 + 12'($urandom_range(0, 15)))
                                                     : 31'($urandom);
            carry_clr  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            carry_mask = 4'($urandom);
            step($sformatf("rand%0d", i));
        end

        // Asynchronous reset mid-traffic: outputs must drop before any clock edge.
        inc_vld = 4'b1111; inc_amt = 16'hFFFF;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        model_reset();
        #1;
        rst = 1'b0;
        idle();
        step("post_reset_idle");
        for (int c = 0; c < NCH; c++) begin
            idle(); rd_en = 1'b1; addr = 5'(c);
            step($sformatf("post_reset_rd%0d", c));
            check($sformatf("post_reset_rd%0d wrap.count", c), 32'(rdata_w), 32'd0);
            check($sformatf("post_reset_rd%0d sat.count", c), 32'(rdata_s), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
